// File: rtl/pong_game_ctrl.sv
// Game-state controller for the ping-pong design: sequences new game, play,
// re-serve and game-over phases, and keeps the ball count and BCD score.
//
// state   | meaning
// --------+-----------------------------------------------------------
// NEWGAME | waiting for a button press to start; graphics frozen
// PLAY    | ball in play; hits score, misses cost a ball
// NEWBALL | re-serve wait; needs timer expiry plus a fresh press
// OVER    | last ball lost; final score shown until the timer expires
module pong_game_ctrl #(
  parameter int BALLS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  input  logic       timer_up,
  output logic       timer_start,
  output logic       gra_still,
  output logic       game_over,
  output logic [2:0] balls_left,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0
);

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [2:0] BALLS_INIT = 3'(BALLS);

  state_t     state, state_next;
  logic       btn_d;
  logic       press;
  logic [2:0] balls_next;
  logic [3:0] d1_next, d0_next;

  // rising edge only, so a button held across a state change is ignored
  assign press = (|btn) & ~btn_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= NEWGAME;
      btn_d      <= 1'b0;
      balls_left <= BALLS_INIT;
      score_d1   <= 4'd0;
      score_d0   <= 4'd0;
    end else begin
      state      <= state_next;
      btn_d      <= |btn;
      balls_left <= balls_next;
      score_d1   <= d1_next;
      score_d0   <= d0_next;
    end
  end

  always_comb begin
    state_next  = state;
    balls_next  = balls_left;
    d1_next     = score_d1;
    d0_next     = score_d0;
    timer_start = 1'b0;
    gra_still   = 1'b1;
    game_over   = 1'b0;
    case (state)
      NEWGAME: begin
        if (press) begin
          state_next = PLAY;
          balls_next = BALLS_INIT;
          d1_next    = 4'd0;
          d0_next    = 4'd0;
        end
      end
      PLAY: begin
        gra_still = 1'b0;
        if (miss) begin
          timer_start = 1'b1;
          if (balls_left > 3'd1) begin
            state_next = NEWBALL;
            balls_next = balls_left - 3'd1;
          end else begin
            state_next = OVER;
            balls_next = 3'd0;
          end
        end else if (hit) begin
          // BCD increment saturating at 99
          if (score_d0 == 4'd9) begin
            if (score_d1 != 4'd9) begin
              d0_next = 4'd0;
              d1_next = score_d1 + 4'd1;
            end
          end else begin
            d0_next = score_d0 + 4'd1;
          end
        end
      end
      NEWBALL: begin
        if (timer_up && press)
          state_next = PLAY;
      end
      OVER: begin
        game_over = 1'b1;
        if (timer_up)
          state_next = NEWGAME;
      end
      default: state_next = NEWGAME;
    endcase
  end

endmodule
